keypad_scan_16: RTL and testbench



---
 rtl/keypad_scan_16.sv | 199 +++++++++++++++++++
 tb/tb_keypad_scan_16.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_16.sv
// rtl/keypad_scan_16.sv - 4x4 matrix keypad scanner with debounce and 4-entry FWFT key FIFO
module keypad_scan_16 #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row_o,
    input  logic [3:0] col_i,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_rd,
    output logic [2:0] fifo_count,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       key_held
);

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_MAX  = 4'(DEBOUNCE_N);

    logic [3:0] col_meta;
    logic [3:0] col_sync;

    // Columns idle high through the pull-ups, so reset to "all released".
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col_i;
            col_sync <= col_meta;
        end
    end

    logic [DIV_W-1:0] div;
    logic [1:0]       r;
    logic             sample;

    assign sample = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= '0;
            r   <= 2'd0;
        end else if (sample) begin
            div <= '0;
            r   <= r + 2'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign row_o = ~(4'b0001 << r);

    logic [15:0] snap;
    logic        frame_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            snap       <= 16'h0000;
            frame_done <= 1'b0;
        end else begin
            frame_done <= sample && (r == 2'd3);
            if (sample) begin
                snap[{r, 2'b00} +: 4] <= ~col_sync;
            end
        end
    end

    logic [15:0] cand;
    logic [15:0] stable;
    logic [3:0]  dcnt;
    logic        push_chk;
    logic [15:0] cand_nxt;
    logic [3:0]  dcnt_nxt;

    always_comb begin
        cand_nxt = cand;
        dcnt_nxt = dcnt;
        if (snap == cand) begin
            if (dcnt < DEB_MAX) begin
                dcnt_nxt = dcnt + 4'd1;
            end
        end else begin
            cand_nxt = snap;
            dcnt_nxt = 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cand     <= 16'h0000;
            stable   <= 16'h0000;
            dcnt     <= 4'd0;
            push_chk <= 1'b0;
        end else begin
            push_chk <= 1'b0;
            if (frame_done) begin
                cand <= cand_nxt;
                dcnt <= dcnt_nxt;
                if ((dcnt_nxt == DEB_MAX) && (cand_nxt != stable)) begin
                    stable   <= cand_nxt;
                    push_chk <= 1'b1;
                end
            end
        end
    end

    assign key_held = |stable;

    logic [3:0] stable_idx;
    logic       one_hot;
    logic [3:0] last_idx;
    logic       last_vld;
    logic       push_req;

    always_comb begin
        stable_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (stable[i]) begin
                stable_idx = i[3:0];
            end
        end
        one_hot = $onehot(stable);
    end

    // last_idx blocks a repeat of the same key until the stable state has been empty.
    assign push_req = push_chk && one_hot && !(last_vld && (stable_idx == last_idx));

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_idx <= 4'd0;
            last_vld <= 1'b0;
        end else if (push_chk) begin
            if (stable == 16'h0000) begin
                last_vld <= 1'b0;
            end else if (push_req) begin
                last_idx <= stable_idx;
                last_vld <= 1'b1;
            end
        end
    end

    logic [3:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic [2:0] count_nxt;
    logic [3:0] shown;
    logic       do_pop;
    logic       do_push;
    logic       drop;

    always_comb begin
        do_pop    = key_rd && (count != 3'd0);
        do_push   = push_req && ((count != 3'd4) || do_pop);
        drop      = push_req && (count == 3'd4) && !do_pop;
        count_nxt = count + {2'b00, do_push} - {2'b00, do_pop};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= 4'h0;
            end
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            key_valid <= 1'b0;
            shown     <= 4'h0;
            overflow  <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= stable_idx;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count     <= count_nxt;
            key_valid <= (count_nxt != 3'd0);
            // Remember the head on display so key_code stays put once drained.
            if (count != 3'd0) begin
                shown <= mem[rd_ptr];
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign key_code   = key_valid ? mem[rd_ptr] : shown;
    assign fifo_count = count;

endmodule

// File: tb/tb_keypad_scan_16.sv
// tb/tb_keypad_scan_16.sv - self-checking bench for keypad_scan_16 with a frame-level keypad model
module tb_keypad_scan_16;

    localparam int SD  = 4;
    localparam int DEB = 2;

    logic       clk;
    logic       rst;
    logic [3:0] row_o;
    logic [3:0] col_i;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_rd;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       ovf_clr;
    logic       key_held;
    logic [15:0] pressed;

    keypad_scan_16 #(.SCAN_DIV(SD), .DEBOUNCE_N(DEB)) dut (
        .clk(clk), .rst(rst), .row_o(row_o), .col_i(col_i),
        .key_valid(key_valid), .key_code(key_code), .key_rd(key_rd),
        .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr),
        .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its column low while its row is driven.
    always_comb begin
        col_i = 4'hF;
        for (int rr = 0; rr < 4; rr++) begin
            if (!row_o[rr]) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[rr*4+c]) col_i[c] = 1'b0;
                end
            end
        end
    end

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Frame-level reference: a key state is accepted once the last DEB frames agree.
    logic [15:0] hist [DEB];
    logic [15:0] stable_m;
    int          q[$];
    int          pend;
    bit          ovf_m;
    int          last_m;
    bit          last_vld_m;
    int          last_shown;
    int          last_pop;

    task automatic model_reset();
        for (int i = 0; i < DEB; i++) hist[i] = 16'h0;
        stable_m   = 16'h0;
        q.delete();
        pend       = -1;
        ovf_m      = 1'b0;
        last_m     = 0;
        last_vld_m = 1'b0;
        last_shown = 0;
    endtask

    task automatic model_frame(input logic [15:0] v);
        bit same;
        int idx;
        for (int i = 0; i < DEB - 1; i++) hist[i] = hist[i+1];
        hist[DEB-1] = v;
        same = 1'b1;
        for (int i = 0; i < DEB; i++) if (hist[i] != v) same = 1'b0;
        if (same && (v != stable_m)) begin
            stable_m = v;
            if (v == 16'h0) begin
                last_vld_m = 1'b0;
            end else if ($countones(v) == 1) begin
                idx = 0;
                for (int i = 0; i < 16; i++) if (v[i]) idx = i;
                if (!(last_vld_m && (idx == last_m))) begin
                    pend       = idx;
                    last_m     = idx;
                    last_vld_m = 1'b1;
                end
            end
        end
    endtask

    task automatic apply_pending();
        if (pend >= 0) begin
            if (q.size() < 4) q.push_back(pend);
            else ovf_m = 1'b1;
            pend = -1;
        end
        if (q.size() > 0) last_shown = q[0];
    endtask

    task automatic model_pop();
        int p;
        if (q.size() > 0) begin
            p = q.pop_front();
            last_shown = (q.size() > 0) ? q[0] : p;
        end
    endtask

    // One 16-cycle scan frame with the keypad held at v; optional pop / ovf_clr at cycle index.
    task automatic frame(input logic [15:0] v, input int pop_at, input int clr_at);
        pressed = v;
        for (int k = 0; k < 16; k++) begin
            if (k == 1) chk("count_before_push", fifo_count, q.size());
            if (k == 2) apply_pending();
            if (k == 4) begin
                chk("fifo_count", fifo_count, q.size());
                chk("key_valid", key_valid, (q.size() > 0));
                chk("overflow", overflow, ovf_m);
                chk("key_held", key_held, (stable_m != 16'h0));
                chk("key_code", key_code, (q.size() > 0) ? q[0] : last_shown);
            end
            if (k == pop_at) begin
                chk("pop_valid", key_valid, (q.size() > 0));
                if (q.size() > 0) chk("pop_code", key_code, q[0]);
                last_pop = key_code;
                key_rd   = 1'b1;
            end
            if (k == clr_at) ovf_clr = 1'b1;
            @(negedge clk);
            if (k == pop_at) begin
                key_rd = 1'b0;
                model_pop();
            end
            if (k == clr_at) begin
                ovf_clr = 1'b0;
                ovf_m   = 1'b0;
            end
        end
        model_frame(v);
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        pressed = 16'h0;
        key_rd  = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_row_o", row_o, 4'b1110);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_code", key_code, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_key_held", key_held, 0);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic press(input int code);
        frame(16'(1) << code, -1, -1);
        frame(16'(1) << code, -1, -1);
        frame(16'h0, -1, -1);
        frame(16'h0, -1, -1);
    endtask

    typedef struct {
        bit         rst_v;
        logic [3:0] row;
        bit         kv;
    } rst_vec_t;

    rst_vec_t rvec [19];
    logic [15:0] v;
    int exp_pops [4];

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        key_rd  = 1'b0;
        ovf_clr = 1'b0;
        pressed = 16'h0;
        last_pop = 0;
        model_reset();

        for (int i = 0; i < 3; i++) rvec[i] = '{1'b0, 4'b1110, 1'b0};
        for (int i = 3; i < 6; i++) rvec[i] = '{1'b1, 4'b1110, 1'b0};
        for (int i = 6; i < 10; i++) rvec[i] = '{1'b1, 4'b1101, 1'b0};
        for (int i = 10; i < 14; i++) rvec[i] = '{1'b1, 4'b1011, 1'b0};
        for (int i = 14; i < 18; i++) rvec[i] = '{1'b1, 4'b0111, 1'b0};
        rvec[18] = '{1'b1, 4'b1110, 1'b0};
        for (int i = 0; i < 19; i++) begin
            rst = rvec[i].rst_v;
            @(negedge clk);
            chk("tbl_row_o", row_o, rvec[i].row);
            chk("tbl_key_valid", key_valid, rvec[i].kv);
        end

        // Single press of key 6, pop, hold without release, then re-press.
        do_reset();
        repeat (3) frame(16'h0040, -1, -1);
        chk("single_valid", key_valid, 1);
        chk("single_code", key_code, 6);
        chk("single_held", key_held, 1);
        frame(16'h0040, 8, -1);
        chk("single_pop", last_pop, 6);
        chk("single_empty", fifo_count, 0);
        repeat (2) frame(16'h0040, -1, -1);
        chk("hold_no_repush", fifo_count, 0);
        repeat (2) frame(16'h0, -1, -1);
        repeat (3) frame(16'h0040, -1, -1);
        chk("repress_code", key_code, 6);
        frame(16'h0, 8, -1);
        chk("repress_pop", last_pop, 6);

        // Bounce on key 9, then steady hold.
        repeat (2) frame(16'h0, -1, -1);
        for (int i = 0; i < 6; i++) frame((i % 2) ? 16'h0200 : 16'h0, -1, -1);
        chk("bounce_no_push", fifo_count, 0);
        repeat (3) frame(16'h0200, -1, -1);
        chk("bounce_one_entry", fifo_count, 1);
        frame(16'h0200, 8, -1);
        chk("bounce_pop", last_pop, 9);
        repeat (2) frame(16'h0, -1, -1);

        // Chord 0+5.
        repeat (3) frame(16'h0021, -1, -1);
        chk("ghost_held", key_held, 1);
        chk("ghost_no_push", fifo_count, 0);
        repeat (2) frame(16'h0, -1, -1);

        // Overflow: five presses without reads.
        for (int c = 1; c <= 5; c++) press(c);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_flag", overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            frame(16'h0, 8, -1);
            chk("ovf_pop", last_pop, i);
        end
        frame(16'h0, -1, 10);
        chk("ovf_cleared", overflow, 0);

        // Full FIFO with pop on the exact push cycle of code 7.
        for (int c = 1; c <= 4; c++) press(c);
        repeat (2) frame(16'h0080, -1, -1);
        frame(16'h0, 1, -1);
        chk("simul_pop", last_pop, 1);
        frame(16'h0, -1, -1);
        chk("simul_count", fifo_count, 4);
        chk("simul_no_ovf", overflow, 0);
        // Dropped push and ovf_clr on the same edge: set wins.
        repeat (2) frame(16'h0100, -1, -1);
        frame(16'h0, -1, 1);
        chk("set_wins", overflow, 1);
        frame(16'h0, -1, 10);
        exp_pops = '{2, 3, 4, 7};
        for (int i = 0; i < 4; i++) begin
            frame(16'h0, 8, -1);
            chk("simul_pop_seq", last_pop, exp_pops[i]);
        end

        // Reset in the middle of debouncing key 11.
        frame(16'h0800, -1, -1);
        pressed = 16'h0800;
        repeat (7) @(negedge clk);
        do_reset();
        repeat (3) frame(16'h0, -1, -1);
        chk("midrst_no_push", fifo_count, 0);
        chk("midrst_not_held", key_held, 0);

        // Randomized keypad activity against the frame-level model.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            int pa;
            int ca;
            int a;
            int b;
            case ($urandom_range(0, 3))
                0: v = 16'h0;
                1, 2: v = 16'(1) << $urandom_range(0, 15);
                default: begin
                    a = $urandom_range(0, 15);
                    b = $urandom_range(0, 15);
                    v = (16'(1) << a) | (16'(1) << b);
                end
            endcase
            repeat ($urandom_range(1, 3)) begin
                case ($urandom_range(0, 3))
                    2: pa = 8;
                    3: pa = 1;
                    default: pa = -1;
                endcase
                ca = ($urandom_range(0, 7) == 0) ? 10 : -1;
                frame(v, pa, ca);
            end
        end
        frame(16'h0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
